// File: rtl/unpool_pkg.sv
// Shared definitions for the unpool (upsampling) stage:
// state encodings, legal window sizes and default geometry.
package unpool_pkg;

    localparam int DEF_DESIGN_SIZE   = 4;
    localparam int DEF_DWIDTH        = 8;
    localparam int DEF_MAX_BITS_POOL = 3;
    localparam int DEF_COUNT_W       = 16;

    // Sub-word index width; the largest legal window is 4.
    localparam int K_W = 2;

    localparam int WIN1 = 1;
    localparam int WIN2 = 2;
    localparam int WIN4 = 4;

    typedef enum logic [1:0] {
        UNPOOL_IDLE   = 2'd0,
        UNPOOL_EXPAND = 2'd1,
        UNPOOL_DONE   = 2'd2
    } unpool_state_t;

    function automatic logic win_legal(input int w);
        return (w == WIN1) || (w == WIN2) || (w == WIN4);
    endfunction

endpackage

// File: rtl/unpool_lane_select.sv
// Combinational lane mapper: builds sub-word k of the expanded word.
// Ports: hold (latched input word), k (sub-word index), win (legal
// window 1/2/4), out_data (expanded word). Macro UNPOOL_ZERO_FILL_EN
// selects zero-insertion instead of replication.
module unpool_lane_select
    import unpool_pkg::*;
#(
    parameter int DESIGN_SIZE   = DEF_DESIGN_SIZE,
    parameter int DWIDTH        = DEF_DWIDTH,
    parameter int MAX_BITS_POOL = DEF_MAX_BITS_POOL
) (
    input  logic [DESIGN_SIZE*DWIDTH-1:0] hold,
    input  logic [K_W-1:0]                k,
    input  logic [MAX_BITS_POOL-1:0]      win,
    output logic [DESIGN_SIZE*DWIDTH-1:0] out_data
);

    localparam int LG_DS = $clog2(DESIGN_SIZE);

    // Windows are powers of two, so the divisions reduce to shifts:
    // src = k*(DESIGN_SIZE/W) + j/W.
    always_comb begin
        int sh;
        int src;
        sh = (int'(win) == WIN4) ? 2 : (int'(win) == WIN2) ? 1 : 0;
        src = 0;
        out_data = '0;
        for (int j = 0; j < DESIGN_SIZE; j++) begin
            src = (int'(k) << (LG_DS - sh)) + (j >> sh);
            out_data[j*DWIDTH +: DWIDTH] = hold[src*DWIDTH +: DWIDTH];
`ifdef UNPOOL_ZERO_FILL_EN
            if ((j & ((1 << sh) - 1)) != 0)
                out_data[j*DWIDTH +: DWIDTH] = '0;
`endif
        end
    end

endmodule

// File: rtl/unpool.sv
// Upsampling stage: expands each accepted input word into W output
// words with valid/ready on both sides; raises done_unpool after
// total_out_words outputs. Ports: clk, reset (async, active-low),
// enable_unpool (0 = bypass), unpool_window_size, total_out_words,
// in_data/in_valid/in_ready, out_data/out_valid/out_ready,
// done_unpool, bad_window (sticky). Optional macro:
// UNPOOL_ZERO_FILL_EN (zero-insertion in the lane mapper).
module unpool
    import unpool_pkg::*;
#(
    parameter int DESIGN_SIZE   = DEF_DESIGN_SIZE,
    parameter int DWIDTH        = DEF_DWIDTH,
    parameter int MAX_BITS_POOL = DEF_MAX_BITS_POOL,
    parameter int COUNT_W       = DEF_COUNT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_unpool,
    input  logic [MAX_BITS_POOL-1:0]      unpool_window_size,
    input  logic [COUNT_W-1:0]            total_out_words,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          done_unpool,
    output logic                          bad_window
);

    localparam int DW = DESIGN_SIZE * DWIDTH;

    unpool_state_t          state;
    unpool_state_t          state_nxt;
    logic [DW-1:0]          hold_q;
    logic [K_W-1:0]         k_q;
    logic [MAX_BITS_POOL-1:0] win_q;
    logic [COUNT_W-1:0]     cnt_q;
    logic                   bad_q;

    logic [DW-1:0]          sel_data;
    logic [MAX_BITS_POOL-1:0] win_in;
    logic                   win_ok;
    logic                   last_k;
    logic                   finishing;
    logic [COUNT_W-1:0]     cnt_inc;
    logic                   accept;
    logic                   out_fire;
    logic                   fsm_in_ready;
    logic                   fsm_out_valid;
    logic                   fsm_done;

    unpool_lane_select #(
        .DESIGN_SIZE   (DESIGN_SIZE),
        .DWIDTH        (DWIDTH),
        .MAX_BITS_POOL (MAX_BITS_POOL)
    ) u_lane_select (
        .hold     (hold_q),
        .k        (k_q),
        .win      (win_q),
        .out_data (sel_data)
    );

    // Illegal windows fall back to W=1 so the word passes unexpanded.
    always_comb begin
        win_ok    = win_legal(int'(unpool_window_size));
        win_in    = win_ok ? unpool_window_size
                           : MAX_BITS_POOL'(WIN1);
        last_k    = (k_q == K_W'(win_q - 1'b1));
        cnt_inc   = cnt_q + 1'b1;
        finishing = (cnt_inc == total_out_words);
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        out_fire      = 1'b0;
        fsm_in_ready  = 1'b0;
        fsm_out_valid = 1'b0;
        fsm_done      = 1'b0;
        unique case (state)
            UNPOOL_IDLE: begin
                if (total_out_words == '0) begin
                    state_nxt = UNPOOL_DONE;
                end else begin
                    fsm_in_ready = 1'b1;
                    if (in_valid) begin
                        accept    = 1'b1;
                        state_nxt = UNPOOL_EXPAND;
                    end
                end
            end
            UNPOOL_EXPAND: begin
                fsm_out_valid = 1'b1;
                if (out_ready) begin
                    out_fire = 1'b1;
                    if (finishing) begin
                        state_nxt = UNPOOL_DONE;
                    end else if (last_k) begin
                        // Back-to-back: take the next word on the last beat.
                        fsm_in_ready = 1'b1;
                        if (in_valid) accept = 1'b1;
                        else          state_nxt = UNPOOL_IDLE;
                    end
                end
            end
            UNPOOL_DONE: begin
                fsm_done = 1'b1;
            end
            default: begin
                state_nxt = UNPOOL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= UNPOOL_IDLE;
            hold_q <= '0;
            k_q    <= '0;
            win_q  <= MAX_BITS_POOL'(WIN1);
            cnt_q  <= '0;
            bad_q  <= 1'b0;
        end else if (!enable_unpool) begin
            state <= UNPOOL_IDLE;
            k_q   <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                hold_q <= in_data;
                k_q    <= '0;
                win_q  <= win_in;
                if (!win_ok) bad_q <= 1'b1;
            end else if (out_fire && !last_k) begin
                k_q <= k_q + 1'b1;
            end
            if (out_fire) cnt_q <= cnt_inc;
        end
    end

    // Outputs are forced low while reset is held, including the
    // combinational bypass path.
    always_comb begin
        out_data    = '0;
        out_valid   = 1'b0;
        in_ready    = 1'b0;
        done_unpool = 1'b0;
        if (reset) begin
            if (!enable_unpool) begin
                out_data    = in_data;
                out_valid   = in_valid;
                in_ready    = out_ready;
                done_unpool = 1'b1;
            end else begin
                out_data    = (state == UNPOOL_EXPAND) ? sel_data : '0;
                out_valid   = fsm_out_valid;
                in_ready    = fsm_in_ready;
                done_unpool = fsm_done;
            end
        end
    end

    assign bad_window = bad_q;

endmodule

// File: tb/tb_unpool.sv
// Scoreboard bench for unpool: directed words, expected outputs
// queued at issue time and checked by an independent monitor.
module tb_unpool;

    logic        clk;
    logic        reset;
    logic        enable_unpool;
    logic [2:0]  unpool_window_size;
    logic [15:0] total_out_words;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        done_unpool;
    logic        bad_window;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          mon_cnt = 0;
    int          cyc = 0;
    int          v_cnt = 0;
    int          v_first = 0;
    int          v_last = 0;
    int          rdy_n = 0;
    int          rdy_pos = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    unpool #(
        .DESIGN_SIZE   (4),
        .DWIDTH        (8),
        .MAX_BITS_POOL (3),
        .COUNT_W       (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enable_unpool      (enable_unpool),
        .unpool_window_size (unpool_window_size),
        .total_out_words    (total_out_words),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .done_unpool        (done_unpool),
        .bad_window         (bad_window)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor: pops on every expanded-mode output handshake and
    // checks that stalled outputs hold steady.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {31'd0, out_valid, out_data},
                    {31'd0, 1'b1, prev_data});
            prev_stall = 1'b0;
            if (enable_unpool) begin
                if (out_valid) begin
                    if (v_cnt == 0) v_first = cyc;
                    v_last = cyc;
                    v_cnt++;
                    if (in_ready) begin
                        rdy_n++;
                        rdy_pos = v_cnt;
                    end
                end
                if (out_valid && out_ready) begin
                    mon_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected actual=%0h required=none",
                                 out_data);
                    end else begin
                        chk("out_word", out_data, exp_q.pop_front());
                    end
                end else if (out_valid) begin
                    prev_stall = 1'b1;
                    prev_data  = out_data;
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit drop);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) fail_now("send_timeout");
        @(posedge clk);
        #1;
        if (drop) in_valid = 1'b0;
    endtask

    // Returns on the edge where output word number 'target' is taken.
    task automatic wait_words(input int target);
        int n;
        n = 0;
        while (mon_cnt < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (mon_cnt < target) fail_now("wait_words");
    endtask

    task automatic idle_cycle();
        enable_unpool = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        reset              = 1'b0;
        enable_unpool      = 1'b0;
        unpool_window_size = 3'd1;
        total_out_words    = 16'd0;
        in_data            = 32'hDEADBEEF;
        in_valid           = 1'b1;
        out_ready          = 1'b1;

        // Reset values, even with bypass inputs active.
        #3;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done_unpool, 0);
        chk("rst_bad", bad_window, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;

        // W=2, total=2.
        unpool_window_size = 3'd2;
        total_out_words    = 16'd2;
        enable_unpool      = 1'b1;
`ifdef UNPOOL_ZERO_FILL_EN
        exp_q.push_back(32'h00220011);
        exp_q.push_back(32'h00440033);
`else
        exp_q.push_back(32'h22221111);
        exp_q.push_back(32'h44443333);
`endif
        base = mon_cnt;
        send(32'h44332211, 1'b1);
        wait_words(base + 2);
        @(negedge clk);
        chk("w2_done", done_unpool, 1);
        chk("w2_done_inrdy", in_ready, 0);
        chk("w2_done_ovalid", out_valid, 0);
        @(posedge clk);
        #1;

        // Bypass.
        enable_unpool = 1'b0;
        in_data       = 32'hA5A5A5A5;
        in_valid      = 1'b1;
        out_ready     = 1'b1;
        #1;
        chk("byp_data", out_data, 32'hA5A5A5A5);
        chk("byp_valid", out_valid, 1);
        chk("byp_done", done_unpool, 1);
        chk("byp_inrdy_hi", in_ready, 1);
        out_ready = 1'b0;
        #1;
        chk("byp_inrdy_lo", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // W=4, two back-to-back words, total=8.
        unpool_window_size = 3'd4;
        total_out_words    = 16'd8;
        enable_unpool      = 1'b1;
        v_cnt = 0;
        rdy_n = 0;
        rdy_pos = 0;
`ifdef UNPOOL_ZERO_FILL_EN
        exp_q.push_back(32'h00000001);
        exp_q.push_back(32'h00000002);
        exp_q.push_back(32'h00000003);
        exp_q.push_back(32'h00000004);
        exp_q.push_back(32'h00000055);
        exp_q.push_back(32'h00000066);
        exp_q.push_back(32'h00000077);
        exp_q.push_back(32'h00000088);
`else
        exp_q.push_back(32'h01010101);
        exp_q.push_back(32'h02020202);
        exp_q.push_back(32'h03030303);
        exp_q.push_back(32'h04040404);
        exp_q.push_back(32'h55555555);
        exp_q.push_back(32'h66666666);
        exp_q.push_back(32'h77777777);
        exp_q.push_back(32'h88888888);
`endif
        base = mon_cnt;
        send(32'h04030201, 1'b0);
        send(32'h88776655, 1'b1);
        wait_words(base + 8);
        @(negedge clk);
        chk("w4_done", done_unpool, 1);
        chk("w4_valid_cycles", v_cnt, 8);
        chk("w4_no_gap", v_last - v_first + 1, 8);
        chk("w4_inrdy_pulses", rdy_n, 1);
        chk("w4_inrdy_pos", rdy_pos, 4);
        @(posedge clk);
        #1;
        idle_cycle();

        // W=2 with out_ready 1,0,0,1.
        unpool_window_size = 3'd2;
        total_out_words    = 16'd2;
        enable_unpool      = 1'b1;
`ifdef UNPOOL_ZERO_FILL_EN
        exp_q.push_back(32'h00BB00AA);
        exp_q.push_back(32'h00DD00CC);
`else
        exp_q.push_back(32'hBBBBAAAA);
        exp_q.push_back(32'hDDDDCCCC);
`endif
        base = mon_cnt;
        send(32'hDDCCBBAA, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_done", done_unpool, 1);
        chk("stall_word_count", mon_cnt - base, 2);
        @(posedge clk);
        #1;
        idle_cycle();

        // Illegal window W=3 passes the word unexpanded.
        unpool_window_size = 3'd3;
        total_out_words    = 16'd1;
        enable_unpool      = 1'b1;
        chk("bad_before", bad_window, 0);
        exp_q.push_back(32'h0D0C0B0A);
        base = mon_cnt;
        send(32'h0D0C0B0A, 1'b1);
        chk("bad_after", bad_window, 1);
        wait_words(base + 1);
        @(negedge clk);
        chk("bad_done", done_unpool, 1);
        @(posedge clk);
        #1;
        idle_cycle();

        // Reset dropped mid-EXPAND.
        unpool_window_size = 3'd4;
        total_out_words    = 16'd8;
        enable_unpool      = 1'b1;
        out_ready          = 1'b0;
        send(32'h12345678, 1'b1);
        @(negedge clk);
        chk("mid_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_inrdy", in_ready, 0);
        chk("arst_bad", bad_window, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("restart_inrdy", in_ready, 1);
        chk("restart_valid", out_valid, 0);
        chk("restart_done", done_unpool, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle_cycle();

        // total_out_words = 0: done next cycle, nothing accepted.
        total_out_words = 16'd0;
        enable_unpool   = 1'b1;
        in_data         = 32'hCAFEF00D;
        in_valid        = 1'b1;
        @(negedge clk);
        chk("zero_done_first", done_unpool, 0);
        chk("zero_inrdy_first", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("zero_done", done_unpool, 1);
        chk("zero_inrdy", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
